// File: rtl/sync_fifo_param_if.sv
// sync_fifo_param_if: handshake/data bundle for sync_fifo_param.
//   D_in, w_en    : write data and write request (producer side)
//   r_en          : read request (consumer side)
//   D_out         : read data
//   full, almost_full, empty, almost_empty, count : occupancy status
//   overflow, underflow : one-cycle rejected-operation pulses
// master: producer/consumer driving requests; slave: the FIFO itself.
interface sync_fifo_param_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3
);
  logic [DATA_W-1:0] D_in;
  logic              w_en;
  logic              full;
  logic              almost_full;
  logic              r_en;
  logic              empty;
  logic              almost_empty;
  logic [DATA_W-1:0] D_out;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;

  modport master (
    output D_in, w_en, r_en,
    input  full, almost_full, empty, almost_empty, D_out, count,
           overflow, underflow
  );

  modport slave (
    input  D_in, w_en, r_en,
    output full, almost_full, empty, almost_empty, D_out, count,
           overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock parametrised FIFO.
//   clk   : rising-edge clock for all state
//   rst_n : asynchronous active-low reset (memory contents not cleared)
//   bus   : sync_fifo_param_if slave (write/read requests, data, flags,
//           occupancy count, overflow/underflow pulses)
// FWFT=0 gives a registered D_out updated one cycle after an accepted read;
// FWFT=1 presents the head word continuously and r_en pops it.
module sync_fifo_param #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ADDR_W    = 3,
  parameter int unsigned AF_THRESH = 6,
  parameter int unsigned AE_THRESH = 2,
  parameter bit          FWFT      = 1'b0
) (
  input logic              clk,
  input logic              rst_n,
  sync_fifo_param_if.slave bus
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] AF_LVL = (ADDR_W + 1)'(AF_THRESH);
  localparam logic [ADDR_W:0] AE_LVL = (ADDR_W + 1)'(AE_THRESH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   wptr;
  logic [ADDR_W:0]   rptr;
  logic [ADDR_W:0]   cnt;
  logic              is_full;
  logic              is_empty;
  logic              wr_ok;
  logic              rd_ok;
  logic              ovf_q;
  logic              unf_q;

  // Flags depend on registered pointers only.
  always_comb begin
    cnt      = wptr - rptr;
    is_empty = (wptr == rptr);
    is_full  = (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]) &&
               (wptr[ADDR_W] != rptr[ADDR_W]);
  end

  // A write into a full FIFO is accepted when a read frees a slot the same
  // cycle; the memory is read-before-write so the popped word is the old one.
  always_comb begin
    rd_ok = bus.r_en & ~is_empty;
    wr_ok = bus.w_en & (~is_full | rd_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) rptr <= rptr + 1'b1;
      ovf_q <= bus.w_en & ~wr_ok;
      unf_q <= bus.r_en & ~rd_ok;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr[ADDR_W-1:0]] <= bus.D_in;
  end

  generate
    if (FWFT) begin : g_fwft
      assign bus.D_out = mem[rptr[ADDR_W-1:0]];
    end else begin : g_std
      logic [DATA_W-1:0] dout_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     dout_q <= '0;
        else if (rd_ok) dout_q <= mem[rptr[ADDR_W-1:0]];
      end
      assign bus.D_out = dout_q;
    end
  endgenerate

  assign bus.count        = cnt;
  assign bus.empty        = is_empty;
  assign bus.full         = is_full;
  assign bus.almost_full  = (cnt >= AF_LVL);
  assign bus.almost_empty = (cnt <= AE_LVL);
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed self-checking bench for sync_fifo_param.
// dut0 uses defaults (FWFT=0); dut1 is the same FIFO with FWFT=1.
module tb_sync_fifo_param;
  logic clk;
  logic rst_n;
  int unsigned vectors;
  int unsigned miscompares;

  sync_fifo_param_if #(.DATA_W(16), .ADDR_W(3)) bus0 ();
  sync_fifo_param_if #(.DATA_W(16), .ADDR_W(3)) bus1 ();

  sync_fifo_param #(.DATA_W(16), .ADDR_W(3), .AF_THRESH(6), .AE_THRESH(2),
                    .FWFT(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  sync_fifo_param #(.DATA_W(16), .ADDR_W(3), .AF_THRESH(6), .AE_THRESH(2),
                    .FWFT(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; outputs are then sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle0();
    bus0.w_en = 1'b0;
    bus0.r_en = 1'b0;
    bus0.D_in = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle0();
    bus1.w_en = 1'b0;
    bus1.r_en = 1'b0;
    bus1.D_in = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    vectors++;
    if (bus0.empty !== 1'b1 || bus0.almost_empty !== 1'b1 || bus0.full !== 1'b0 ||
        bus0.almost_full !== 1'b0) begin
      $display("FAIL reset_flags: e=%b ae=%b f=%b af=%b, want 1 1 0 0",
               bus0.empty, bus0.almost_empty, bus0.full, bus0.almost_full);
      miscompares++;
    end
    vectors++;
    if (bus0.count !== 4'd0 || bus0.D_out !== 16'h0000) begin
      $display("FAIL reset_data: count=%0d D_out=%h, want 0 0000", bus0.count, bus0.D_out);
      miscompares++;
    end
    vectors++;
    if (bus0.overflow !== 1'b0 || bus0.underflow !== 1'b0) begin
      $display("FAIL reset_pulses: ovf=%b unf=%b, want 0 0", bus0.overflow, bus0.underflow);
      miscompares++;
    end
  endtask

  task automatic test_basic();
    for (int i = 0; i < 4; i++) begin
      bus0.w_en = 1'b1;
      bus0.D_in = 16'(5 + i);
      tick();
      vectors++;
      if (bus0.count !== 4'(i + 1) || bus0.almost_empty !== (i < 2)) begin
        $display("FAIL basic_wr%0d: count=%0d ae=%b, want %0d %b",
                 i, bus0.count, bus0.almost_empty, i + 1, (i < 2));
        miscompares++;
      end
    end
    idle0();
    for (int i = 0; i < 4; i++) begin
      bus0.r_en = 1'b1;
      tick();
      vectors++;
      if (bus0.D_out !== 16'(5 + i) || bus0.count !== 4'(3 - i) ||
          bus0.almost_empty !== (i >= 1)) begin
        $display("FAIL basic_rd%0d: D_out=%h count=%0d ae=%b, want %h %0d %b",
                 i, bus0.D_out, bus0.count, bus0.almost_empty, 16'(5 + i), 3 - i, (i >= 1));
        miscompares++;
      end
    end
    idle0();
    tick();
    vectors++;
    if (bus0.D_out !== 16'h0008 || bus0.empty !== 1'b1) begin
      $display("FAIL basic_hold: D_out=%h empty=%b, want 0008 1", bus0.D_out, bus0.empty);
      miscompares++;
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 5; i++) begin
      bus0.w_en = 1'b1;
      bus0.D_in = 16'(16'h0100 + i);
      tick();
    end
    idle0();
    vectors++;
    if (bus0.count !== 4'd5) begin
      $display("FAIL midrst_pre: count=%0d, want 5", bus0.count);
      miscompares++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus0.count !== 4'd0 || bus0.empty !== 1'b1 || bus0.almost_empty !== 1'b1 ||
        bus0.full !== 1'b0 || bus0.D_out !== 16'h0000) begin
      $display("FAIL midrst: count=%0d e=%b ae=%b f=%b D_out=%h, want 0 1 1 0 0000",
               bus0.count, bus0.empty, bus0.almost_empty, bus0.full, bus0.D_out);
      miscompares++;
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_full_overflow();
    for (int i = 0; i < 9; i++) begin
      bus0.w_en = 1'b1;
      bus0.D_in = 16'(i);
      tick();
      if (i == 5) begin
        vectors++;
        if (bus0.almost_full !== 1'b1 || bus0.full !== 1'b0) begin
          $display("FAIL af_at6: af=%b f=%b, want 1 0", bus0.almost_full, bus0.full);
          miscompares++;
        end
      end
      if (i == 7) begin
        vectors++;
        if (bus0.full !== 1'b1 || bus0.almost_full !== 1'b1 || bus0.count !== 4'd8 ||
            bus0.overflow !== 1'b0) begin
          $display("FAIL full_at8: f=%b af=%b count=%0d ovf=%b, want 1 1 8 0",
                   bus0.full, bus0.almost_full, bus0.count, bus0.overflow);
          miscompares++;
        end
      end
    end
    idle0();
    vectors++;
    if (bus0.overflow !== 1'b1 || bus0.count !== 4'd8) begin
      $display("FAIL ovf_pulse: ovf=%b count=%0d, want 1 8", bus0.overflow, bus0.count);
      miscompares++;
    end
    tick();
    vectors++;
    if (bus0.overflow !== 1'b0) begin
      $display("FAIL ovf_clear: ovf=%b, want 0", bus0.overflow);
      miscompares++;
    end
    for (int i = 0; i < 8; i++) begin
      bus0.r_en = 1'b1;
      tick();
      vectors++;
      if (bus0.D_out !== 16'(i)) begin
        $display("FAIL drain%0d: D_out=%h, want %h", i, bus0.D_out, 16'(i));
        miscompares++;
      end
    end
    idle0();
    vectors++;
    if (bus0.empty !== 1'b1 || bus0.count !== 4'd0) begin
      $display("FAIL drain_end: empty=%b count=%0d, want 1 0", bus0.empty, bus0.count);
      miscompares++;
    end
  endtask

  task automatic test_full_rw();
    for (int i = 0; i < 8; i++) begin
      bus0.w_en = 1'b1;
      bus0.D_in = 16'(i);
      tick();
    end
    bus0.w_en = 1'b1;
    bus0.r_en = 1'b1;
    bus0.D_in = 16'hAAAA;
    tick();
    idle0();
    vectors++;
    if (bus0.D_out !== 16'h0000 || bus0.count !== 4'd8 || bus0.full !== 1'b1 ||
        bus0.overflow !== 1'b0 || bus0.underflow !== 1'b0) begin
      $display("FAIL full_rw: D_out=%h count=%0d f=%b ovf=%b unf=%b, want 0000 8 1 0 0",
               bus0.D_out, bus0.count, bus0.full, bus0.overflow, bus0.underflow);
      miscompares++;
    end
    for (int i = 0; i < 8; i++) begin
      bus0.r_en = 1'b1;
      tick();
      vectors++;
      if (bus0.D_out !== ((i == 7) ? 16'hAAAA : 16'(i + 1))) begin
        $display("FAIL full_rw_drain%0d: D_out=%h, want %h", i, bus0.D_out,
                 (i == 7) ? 16'hAAAA : 16'(i + 1));
        miscompares++;
      end
    end
    idle0();
  endtask

  task automatic test_empty_rw();
    bus0.w_en = 1'b1;
    bus0.r_en = 1'b1;
    bus0.D_in = 16'h0003;
    tick();
    idle0();
    vectors++;
    if (bus0.underflow !== 1'b1 || bus0.count !== 4'd1 || bus0.D_out !== 16'hAAAA) begin
      $display("FAIL empty_rw: unf=%b count=%0d D_out=%h, want 1 1 aaaa",
               bus0.underflow, bus0.count, bus0.D_out);
      miscompares++;
    end
    bus0.r_en = 1'b1;
    tick();
    idle0();
    vectors++;
    if (bus0.D_out !== 16'h0003 || bus0.underflow !== 1'b0 || bus0.count !== 4'd0) begin
      $display("FAIL empty_rw_read: D_out=%h unf=%b count=%0d, want 0003 0 0",
               bus0.D_out, bus0.underflow, bus0.count);
      miscompares++;
    end
  endtask

  task automatic test_wrap();
    logic [15:0] v;
    for (int i = 0; i < 20; i++) begin
      v = 16'(16'h5A00 + i * 7);
      bus0.w_en = 1'b1;
      bus0.D_in = v;
      tick();
      idle0();
      bus0.r_en = 1'b1;
      tick();
      idle0();
      vectors++;
      if (bus0.D_out !== v || bus0.count !== 4'd0 || bus0.overflow !== 1'b0 ||
          bus0.underflow !== 1'b0 || bus0.full !== 1'b0 || bus0.empty !== 1'b1) begin
        $display("FAIL wrap%0d: D_out=%h count=%0d ovf=%b unf=%b f=%b e=%b, want %h 0 0 0 0 1",
                 i, bus0.D_out, bus0.count, bus0.overflow, bus0.underflow,
                 bus0.full, bus0.empty, v);
        miscompares++;
      end
    end
  endtask

  task automatic test_fwft();
    bus1.w_en = 1'b1;
    bus1.D_in = 16'h1234;
    tick();
    bus1.w_en = 1'b0;
    bus1.D_in = '0;
    vectors++;
    if (bus1.empty !== 1'b0 || bus1.D_out !== 16'h1234 || bus1.count !== 4'd1) begin
      $display("FAIL fwft_present: empty=%b D_out=%h count=%0d, want 0 1234 1",
               bus1.empty, bus1.D_out, bus1.count);
      miscompares++;
    end
    tick();
    vectors++;
    if (bus1.D_out !== 16'h1234) begin
      $display("FAIL fwft_hold: D_out=%h, want 1234", bus1.D_out);
      miscompares++;
    end
    bus1.r_en = 1'b1;
    tick();
    bus1.r_en = 1'b0;
    vectors++;
    if (bus1.empty !== 1'b1 || bus1.count !== 4'd0 || bus1.underflow !== 1'b0) begin
      $display("FAIL fwft_pop: empty=%b count=%0d unf=%b, want 1 0 0",
               bus1.empty, bus1.count, bus1.underflow);
      miscompares++;
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_mid_reset();
    test_full_overflow();
    test_full_rw();
    test_empty_rw();
    test_wrap();
    test_fwft();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Single-clock, parametrised FIFO. It is the next-generation buffer for same-domain producer/consumer paths that do not need clock crossing.
- Generalises the fixed 16-bit, 8-entry FIFO to configurable data width and depth.
- Adds programmable almost-full and almost-empty thresholds, an occupancy count, overflow/underflow pulses, and a selectable first-word-fall-through (FWFT) read mode.

Parameters:
- DATA_W, 16, data word width in bits.
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W entries (default 8).
- AF_THRESH, 6, almost_full asserts when count >= AF_THRESH (legal range 1..DEPTH).
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH (legal range 0..DEPTH-1).
- FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through.

Ports:
- clk  in  1  single clock for all state; rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- D_in  in  DATA_W  write data.
- w_en  in  1  write request.
- full  out  1  FIFO holds DEPTH entries.
- almost_full  out  1  count >= AF_THRESH.
- r_en  in  1  read request.
- empty  out  1  FIFO holds 0 entries.
- almost_empty  out  1  count <= AE_THRESH.
- D_out  out  DATA_W  read data.
- count  out  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow  out  1  one-cycle pulse: write rejected.
- underflow  out  1  one-cycle pulse: read rejected.

Behaviour:
- Reset (rst_n low, asynchronous assert, synchronous-safe deassert by the system):
  - wptr = rptr = 0; count = 0.
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0.
  - overflow = underflow = 0; D_out = 0.
  - Memory contents are not reset.
  - Reset mid-operation discards all stored data immediately.
- Pointers are ADDR_W+1 bits; the MSB is the wrap bit.
  - empty when wptr == rptr.
  - full when the addresses are equal and the wrap bits differ.
  - count = wptr - rptr, modulo 2**(ADDR_W+1).
- All flags and count are functions of registered pointers only. No combinational path from w_en/r_en to any flag.
- Accept rules:
  - wr_ok = w_en & (~full | rd_ok).
  - rd_ok = r_en & ~empty.
- On wr_ok: mem[wptr[ADDR_W-1:0]] <= D_in; wptr increments by 1.
- On rd_ok: rptr increments by 1.
- Simultaneous accepted read and write: count unchanged.
- Full + w_en + r_en: both are accepted; the slot freed by the read is rewritten in the same cycle. The RAM must be read-before-write or use separate ports, so the read returns the old word.
- Empty + w_en + r_en: write accepted, read rejected, underflow pulses.
- overflow is registered: high for exactly the one cycle after w_en & ~wr_ok.
- underflow is registered: high for exactly the one cycle after r_en & ~rd_ok.
- Rejected operations do not change pointers, memory or D_out.
- FWFT=0:
  - D_out <= mem[rptr] registered on rd_ok; one-cycle read latency.
  - D_out holds its value when no read is accepted.
- FWFT=1:
  - D_out continuously presents the head word mem[rptr].
  - empty deasserts the cycle after the first accepted write.
  - r_en acknowledges (pops) the presented word.
  - D_out value while empty is don't-care; the bench must not check it.
- Wrap-around: addresses wrap modulo DEPTH; the wrap bit toggles on each pass. Behaviour is seamless across wrap.
- No configuration state machine. The only sequential state is the two pointers, the memory, D_out and the two pulse registers.

Test Plan:
- Reset then idle, FWFT=0, defaults -> empty=1, almost_empty=1, full=0, count=0, D_out=0. rst_n low mid-stream with count=5 -> same values within the same cycle, before the next clk edge.
- Write 5,6,7,8 on consecutive cycles, then read 4 -> D_out is 5,6,7,8, each one cycle after its r_en. count steps 1,2,3,4 then down to 0. almost_empty deasserts when count reaches 3.
- Write 0..8 (9 writes, DEPTH=8) -> full=1 and almost_full=1 after the 8th write. The 9th write is rejected: overflow pulses one cycle, count stays 8. Draining returns 0..7 in order.
- Full FIFO, assert w_en and r_en together with D_in=16'hAAAA -> head word 0 read out, count stays 8, 16'hAAAA appears last on drain.
- Empty FIFO, r_en with w_en, D_in=16'h0003 -> underflow pulse, count=1. Next read returns 16'h0003. Then 20 write/read cycles across wrap -> data sequence intact, no flags spuriously set.
- FWFT=1: write 16'h1234 -> next cycle empty=0 and D_out=16'h1234 with no r_en. r_en pops it -> empty=1, count=0.
